fcvt_wu_s: RTL and testbench
============================

FCVT_WU_S -- requirements
Module: fcvt_wu_s

Interface
REQ-001 The block SHALL have these ports: clk  input  1  clock, rising-edge active.
REQ-002 The block SHALL have these ports: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 The block SHALL have these ports: valid_input  input  1  operand valid, one conversion per asserted cycle.
REQ-004 The block SHALL have these ports: a  input  32  IEEE-754 binary32 operand.
REQ-005 The block SHALL have these ports: rm  input  3  static rounding mode (000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM); DYN is resolved upstream.
REQ-006 The block SHALL have these ports: valid_output  output  1  result valid.
REQ-007 The block SHALL have these ports: y  output  32  unsigned 32-bit integer result.
REQ-008 The block SHALL have these ports: fflags  output  5  {NV,DZ,OF,UF,NX}; DZ, OF and UF are always 0.

Function
REQ-009 The block SHALL implement RISC-V FCVT.WU.S: a binary32 input converts to an unsigned 32-bit integer, rounded per rm.
REQ-010 The block SHALL be fully pipelined with three register stages and no backpressure, accepting one operand every cycle.
REQ-011 valid_output SHALL assert exactly 3 cycles after valid_input is sampled high, and y and fflags SHALL be valid in that same cycle.
REQ-012 Stage 1 SHALL register the sign, exponent and 24-bit significand (hidden bit 0 when exponent is 0), rm, and the class flags nan, inf and zero.
REQ-013 Stage 2 SHALL align the significand to an integer.
  - Right shift by (150 - e) when e < 150, capturing guard and sticky; e <= 125 yields integer 0 with guard/sticky from the full significand (sticky only for e <= 125 except guard for e=126).
  - Left shift by (e - 150) when 150 <= e <= 158.
  - Set overflow when e >= 159.
REQ-014 Stage 3 SHALL increment the integer according to rm:
  - RNE: guard & (sticky | lsb).
  - RTZ: never.
  - RDN: sign & (guard | sticky).
  - RUP: !sign & (guard | sticky).
  - RMM: guard.
REQ-015 Stage 3 SHALL apply saturation and set flags, evaluated in this order:
  - NaN: y=0xFFFFFFFF, NV=1.
  - +inf or positive overflow, including a carry-out of the 32-bit round add: y=0xFFFFFFFF, NV=1.
  - -inf: y=0, NV=1.
  - Negative operand whose rounded magnitude is >= 1: y=0, NV=1, NX=0.
  - Negative operand that rounds to 0: y=0, NV=0, NX=(guard|sticky).
  - Otherwise: y=rounded integer, NX=(guard|sticky).
REQ-016 +0 and -0 SHALL produce y=0 with fflags=0.
REQ-017 Subnormal inputs SHALL be converted as nonzero values of magnitude below 1, and SHALL set NX.
REQ-018 Reserved rm encodings 101 and 110 SHALL behave as RNE.
REQ-019 NV and NX SHALL never both be set for a single result.
REQ-020 y and fflags SHALL update only in cycles where the stage-3 valid bit is set, and SHALL otherwise hold their last value.
REQ-021 Each stage's valid bit SHALL always follow the previous stage, so bubbles propagate unchanged.
REQ-022 Back-to-back operands SHALL not interact: each result depends only on its own a and rm.

Reset
REQ-023 On rst_n low, all pipeline valid bits, valid_output, y and fflags SHALL clear to 0 asynchronously.
REQ-024 Operands in flight when reset asserts SHALL be discarded, and no valid_output SHALL appear for them after release.
REQ-025 After reset release, the first valid_output SHALL be exactly 3 cycles after the first sampled valid_input.

Structure
REQ-026 The shared FP package SHALL hold:
  - binary32 field widths and the bias constant 127.
  - the rm encodings.
  - the fflags bit positions.
  - the canonical unsigned saturation constant 0xFFFFFFFF.
REQ-027 The right shift with sticky collection SHALL be a sub-module named shr_sticky (34-bit in, shift amount, 32-bit out plus guard and sticky), reusable by fcvt_w_s.

Verification
REQ-028 The bench SHALL check a=0x3FC00000 (1.5) with rm=RNE -> y=2, fflags=0x01; a=0x40200000 (2.5) with rm=RNE -> y=2, fflags=0x01; same with rm=RUP -> y=3.
REQ-029 The bench SHALL check a=0x4F7FFFFF -> y=0xFFFFFF00, fflags=0; a=0x4F800000 -> y=0xFFFFFFFF, fflags=0x10; a=0x7FC00000 -> y=0xFFFFFFFF, fflags=0x10.
REQ-030 The bench SHALL check a=0xBECCCCCD (-0.4) with rm=RTZ -> y=0, fflags=0x01; a=0xBF800000 (-1.0) -> y=0, fflags=0x10; a=0xFF800000 -> y=0, fflags=0x10.
REQ-031 The bench SHALL check a=0x00000001 with rm=RUP -> y=1, fflags=0x01; a=0x80000000 -> y=0, fflags=0.
REQ-032 The bench SHALL drive 100 random operands back-to-back with valid high and check: valid_output high for exactly 100 consecutive cycles starting 3 cycles later, and results matching a reference model in order.
REQ-033 The bench SHALL assert rst_n low with 2 operands in flight, then release it, and check: valid_output stays 0, y=0 and fflags=0 until a new operand is accepted and 3 cycles elapse.

Source files
------------

// File: rtl/fcvt_wu_s_pkg.sv
// Shared binary32 field layout, rounding modes, flag positions and the
// rounding-increment decision used by the float-to-integer converters.
package fcvt_wu_s_pkg;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned SIG_W  = 24;
  localparam int unsigned INT_W  = 32;
  localparam int unsigned BIAS   = 127;

  // Biased exponent at which the significand LSB has weight 1, and the
  // first exponent whose value no longer fits in 32 unsigned bits.
  localparam logic [EXP_W-1:0] EXP_INT_LSB = 8'd150;
  localparam logic [EXP_W-1:0] EXP_OVF     = 8'd159;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100
  } rm_e;

  localparam int unsigned FF_NV = 4;
  localparam int unsigned FF_DZ = 3;
  localparam int unsigned FF_OF = 2;
  localparam int unsigned FF_UF = 1;
  localparam int unsigned FF_NX = 0;

  localparam logic [INT_W-1:0] UINT_SAT = 32'hFFFF_FFFF;

  // Magnitude increment decision; reserved encodings fall through to RNE.
  function automatic logic round_inc(input logic [2:0] rm, input logic sign,
                                     input logic lsb, input logic guard,
                                     input logic sticky);
    case (rm)
      RM_RTZ:  return 1'b0;
      RM_RDN:  return sign & (guard | sticky);
      RM_RUP:  return ~sign & (guard | sticky);
      RM_RMM:  return guard;
      default: return guard & (sticky | lsb);
    endcase
  endfunction

endpackage

// File: rtl/fcvt_wu_s_shr_sticky.sv
// Right shift of a 34-bit value to a 32-bit result, collecting the first
// shifted-out bit as guard and the OR of the rest as sticky.
module shr_sticky (
  input  logic [33:0] din,
  input  logic [5:0]  shamt,
  output logic [31:0] dout,
  output logic        guard,
  output logic        sticky
);

  logic [67:0] ext;
  logic [1:0]  unused_hi;

  // Shift into a double-width window so guard/sticky fall out directly;
  // amounts beyond the window leave only sticky.
  always_comb begin
    ext = {din, 34'b0} >> shamt;
    if (shamt > 6'd34) begin
      dout   = '0;
      guard  = 1'b0;
      sticky = |din;
    end else begin
      dout   = ext[65:34];
      guard  = ext[33];
      sticky = |ext[32:0];
    end
  end

  assign unused_hi = ext[67:66];

endmodule

// File: rtl/fcvt_wu_s.sv
// FCVT.WU.S: binary32 to unsigned 32-bit integer, three register stages
// (unpack, align, round/saturate), one operand per cycle.
module fcvt_wu_s
  import fcvt_wu_s_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_input,
  input  logic [31:0] a,
  input  logic [2:0]  rm,
  output logic        valid_output,
  output logic [31:0] y,
  output logic [4:0]  fflags
);

  // Stage 1 state
  logic              s1_valid, s1_sign, s1_nan, s1_inf, s1_zero;
  logic [EXP_W-1:0]  s1_exp;
  logic [SIG_W-1:0]  s1_sig;
  logic [2:0]        s1_rm;

  // Stage 2 state
  logic              s2_valid, s2_sign, s2_nan, s2_inf, s2_zero, s2_ovf;
  logic              s2_guard, s2_sticky;
  logic [INT_W-1:0]  s2_int;
  logic [2:0]        s2_rm;

  logic [EXP_W-1:0]  a_exp;
  logic [FRAC_W-1:0] a_frac;

  assign a_exp  = a[30:23];
  assign a_frac = a[22:0];

  // Stage 1: unpack fields and classify the operand.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_exp   <= '0;
      s1_sig   <= '0;
      s1_rm    <= '0;
      s1_nan   <= 1'b0;
      s1_inf   <= 1'b0;
      s1_zero  <= 1'b0;
    end else begin
      s1_valid <= valid_input;
      s1_sign  <= a[31];
      s1_exp   <= a_exp;
      s1_sig   <= {|a_exp, a_frac};
      s1_rm    <= rm;
      s1_nan   <= (&a_exp) & (|a_frac);
      s1_inf   <= (&a_exp) & ~(|a_frac);
      s1_zero  <= ~(|a_exp) & ~(|a_frac);
    end
  end

  logic [EXP_W-1:0] rdist, ldist;
  logic [5:0]       shamt;
  logic [INT_W-1:0] rsh_int, lsh_int;
  logic             rsh_guard, rsh_sticky;
  logic [INT_W-1:0] int_d;
  logic             guard_d, sticky_d, ovf_d;

  // Subnormals (exp 0) land in the saturated shift, giving integer 0 with sticky.
  assign rdist   = EXP_INT_LSB - s1_exp;
  assign ldist   = s1_exp - EXP_INT_LSB;
  assign shamt   = (rdist > 8'd63) ? 6'd63 : rdist[5:0];
  assign lsh_int = {8'b0, s1_sig} << ldist;

  shr_sticky u_shr (
    .din    ({10'b0, s1_sig}),
    .shamt  (shamt),
    .dout   (rsh_int),
    .guard  (rsh_guard),
    .sticky (rsh_sticky)
  );

  // Stage 2 datapath: pick right shift, left shift or overflow by exponent.
  always_comb begin
    int_d    = '0;
    guard_d  = 1'b0;
    sticky_d = 1'b0;
    ovf_d    = 1'b0;
    if (s1_exp >= EXP_OVF) begin
      ovf_d = 1'b1;
    end else if (s1_exp >= EXP_INT_LSB) begin
      int_d = lsh_int;
    end else begin
      int_d    = rsh_int;
      guard_d  = rsh_guard;
      sticky_d = rsh_sticky;
    end
  end

  // Stage 2: register the aligned integer and rounding bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      s2_sign   <= 1'b0;
      s2_rm     <= '0;
      s2_nan    <= 1'b0;
      s2_inf    <= 1'b0;
      s2_zero   <= 1'b0;
      s2_ovf    <= 1'b0;
      s2_int    <= '0;
      s2_guard  <= 1'b0;
      s2_sticky <= 1'b0;
    end else begin
      s2_valid  <= s1_valid;
      s2_sign   <= s1_sign;
      s2_rm     <= s1_rm;
      s2_nan    <= s1_nan;
      s2_inf    <= s1_inf;
      s2_zero   <= s1_zero;
      s2_ovf    <= ovf_d;
      s2_int    <= int_d;
      s2_guard  <= guard_d;
      s2_sticky <= sticky_d;
    end
  end

  logic              inc, inexact, big;
  logic [INT_W:0]    sum;
  logic [INT_W-1:0]  res_y;
  logic [4:0]        res_flags;

  assign inc     = round_inc(s2_rm, s2_sign, s2_int[0], s2_guard, s2_sticky);
  assign sum     = {1'b0, s2_int} + {{INT_W{1'b0}}, inc};
  assign inexact = s2_guard | s2_sticky;
  assign big     = s2_ovf | sum[INT_W];

  // Stage 3 datapath: saturation and flags in priority order.
  always_comb begin
    res_y     = '0;
    res_flags = '0;
    if (s2_nan) begin
      res_y            = UINT_SAT;
      res_flags[FF_NV] = 1'b1;
    end else if (!s2_sign && (s2_inf || big)) begin
      res_y            = UINT_SAT;
      res_flags[FF_NV] = 1'b1;
    end else if (s2_zero) begin
      res_y = '0;
    end else if (s2_sign && (s2_inf || big || (|sum[INT_W-1:0]))) begin
      res_flags[FF_NV] = 1'b1;
    end else if (s2_sign) begin
      res_flags[FF_NX] = inexact;
    end else begin
      res_y            = sum[INT_W-1:0];
      res_flags[FF_NX] = inexact;
    end
  end

  // Stage 3: result registers update only for valid slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_output <= 1'b0;
      y            <= '0;
      fflags       <= '0;
    end else begin
      valid_output <= s2_valid;
      if (s2_valid) begin
        y      <= res_y;
        fflags <= res_flags;
      end
    end
  end

endmodule

// File: tb/tb_fcvt_wu_s.sv
// Directed vector table, random back-to-back stream against an
// independent reference model, and reset-with-operands-in-flight.
module tb_fcvt_wu_s;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_input;
  logic [31:0] a;
  logic [2:0]  rm;
  logic        valid_output;
  logic [31:0] y;
  logic [4:0]  fflags;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fcvt_wu_s dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_input  (valid_input),
    .a            (a),
    .rm           (rm),
    .valid_output (valid_output),
    .y            (y),
    .fflags       (fflags)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [2:0]  rm;
    logic [31:0] y;
    logic [4:0]  ff;
  } vec_t;

  localparam int NV = 25;
  localparam int NR = 100;
  vec_t vecs [NV];
  logic [36:0] rexp [NR];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Reference: integer part plus remainder compared against one half.
  function automatic logic [36:0] ref_model(input logic [31:0] av, input logic [2:0] rmv);
    int e;
    int sh;
    logic sgn, inx, incr;
    longint unsigned sig, ip, rem, half, mag;
    e   = int'(av[30:23]);
    sgn = av[31];
    if (e == 255) begin
      if (av[22:0] != 0) return {32'hFFFF_FFFF, 5'h10};
      return sgn ? {32'h0, 5'h10} : {32'hFFFF_FFFF, 5'h10};
    end
    sig = (e == 0) ? longint'(av[22:0]) : (longint'(av[22:0]) | 64'h80_0000);
    if (e == 0) e = 1;
    if (e >= 150) begin
      ip   = (e - 150 > 30) ? 64'h1_0000_0000_0000 : (sig << (e - 150));
      rem  = 0;
      half = 1;
    end else begin
      sh = 150 - e;
      if (sh >= 40) begin
        ip   = 0;
        rem  = sig;
        half = 64'd1 << 39;
      end else begin
        ip   = sig >> sh;
        rem  = sig & ((64'd1 << sh) - 1);
        half = 64'd1 << (sh - 1);
      end
    end
    inx = (rem != 0);
    case (rmv)
      3'd1:    incr = 1'b0;
      3'd2:    incr = sgn & inx;
      3'd3:    incr = ~sgn & inx;
      3'd4:    incr = (rem >= half);
      default: incr = (rem > half) || ((rem == half) && ip[0]);
    endcase
    mag = ip + (incr ? 64'd1 : 64'd0);
    if (sgn) begin
      if (mag != 0) return {32'h0, 5'h10};
      return {32'h0, 4'h0, inx};
    end
    if (mag > 64'hFFFF_FFFF) return {32'hFFFF_FFFF, 5'h10};
    return {mag[31:0], 4'h0, inx};
  endfunction

  initial begin
    rst_n       = 1'b0;
    valid_input = 1'b0;
    a           = '0;
    rm          = '0;

    vecs[0]  = '{32'h3FC00000, 3'd0, 32'h00000002, 5'h01};
    vecs[1]  = '{32'h40200000, 3'd0, 32'h00000002, 5'h01};
    vecs[2]  = '{32'h40200000, 3'd3, 32'h00000003, 5'h01};
    vecs[3]  = '{32'h4F7FFFFF, 3'd0, 32'hFFFFFF00, 5'h00};
    vecs[4]  = '{32'h4F800000, 3'd0, 32'hFFFFFFFF, 5'h10};
    vecs[5]  = '{32'h7FC00000, 3'd0, 32'hFFFFFFFF, 5'h10};
    vecs[6]  = '{32'hBECCCCCD, 3'd1, 32'h00000000, 5'h01};
    vecs[7]  = '{32'hBF800000, 3'd0, 32'h00000000, 5'h10};
    vecs[8]  = '{32'hFF800000, 3'd0, 32'h00000000, 5'h10};
    vecs[9]  = '{32'h00000001, 3'd3, 32'h00000001, 5'h01};
    vecs[10] = '{32'h80000000, 3'd0, 32'h00000000, 5'h00};
    vecs[11] = '{32'h00000000, 3'd0, 32'h00000000, 5'h00};
    vecs[12] = '{32'h7F800000, 3'd1, 32'hFFFFFFFF, 5'h10};
    vecs[13] = '{32'h3F000000, 3'd0, 32'h00000000, 5'h01};
    vecs[14] = '{32'h3F000000, 3'd4, 32'h00000001, 5'h01};
    vecs[15] = '{32'h40200000, 3'd5, 32'h00000002, 5'h01};
    vecs[16] = '{32'h40600000, 3'd6, 32'h00000004, 5'h01};
    vecs[17] = '{32'hBECCCCCD, 3'd2, 32'h00000000, 5'h10};
    vecs[18] = '{32'h3F7FFFFF, 3'd3, 32'h00000001, 5'h01};
    vecs[19] = '{32'h3FFFFFFF, 3'd1, 32'h00000001, 5'h01};
    vecs[20] = '{32'hC0000000, 3'd1, 32'h00000000, 5'h10};
    vecs[21] = '{32'h80000001, 3'd2, 32'h00000000, 5'h10};
    vecs[22] = '{32'h80000001, 3'd1, 32'h00000000, 5'h01};
    vecs[23] = '{32'h4B800001, 3'd0, 32'h01000002, 5'h00};
    vecs[24] = '{32'h3F800000, 3'd0, 32'h00000001, 5'h00};

    repeat (2) @(negedge clk);
    check("reset_valid", 32'(valid_output), 32'd0);
    check("reset_y", y, 32'd0);
    check("reset_fflags", 32'(fflags), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed table: exact latency, result, then hold while idle.
    for (int i = 0; i < NV; i++) begin
      valid_input = 1'b1;
      a           = vecs[i].a;
      rm          = vecs[i].rm;
      @(negedge clk);
      valid_input = 1'b0;
      @(negedge clk);
      check($sformatf("vec%0d_early_valid", i), 32'(valid_output), 32'd0);
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), 32'(valid_output), 32'd1);
      check($sformatf("vec%0d_y", i), y, vecs[i].y);
      check($sformatf("vec%0d_fflags", i), 32'(fflags), 32'(vecs[i].ff));
      @(negedge clk);
      check($sformatf("vec%0d_valid_drop", i), 32'(valid_output), 32'd0);
      check($sformatf("vec%0d_y_hold", i), y, vecs[i].y);
    end

    // Back-to-back random stream; output of slot j is visible 3 negedges later.
    for (int i = 0; i < NR + 6; i++) begin
      if (i >= 3 && i < NR + 3) begin
        check($sformatf("rnd%0d_valid", i - 3), 32'(valid_output), 32'd1);
        check($sformatf("rnd%0d_y", i - 3), y, rexp[i-3][36:5]);
        check($sformatf("rnd%0d_fflags", i - 3), 32'(fflags), 32'(rexp[i-3][4:0]));
      end else begin
        check($sformatf("rnd_idle%0d_valid", i), 32'(valid_output), 32'd0);
      end
      if (i < NR) begin
        logic [7:0] ex;
        int unsigned k;
        k = $urandom_range(0, 9);
        if (k < 7)       ex = 8'($urandom_range(120, 160));
        else if (k == 7) ex = 8'($urandom_range(0, 255));
        else if (k == 8) ex = 8'd0;
        else             ex = ($urandom_range(0, 1) != 0) ? 8'd255 : 8'd158;
        valid_input = 1'b1;
        a           = {1'($urandom_range(0, 1)), ex, 23'($urandom)};
        rm          = 3'($urandom_range(0, 6));
        rexp[i]     = ref_model(a, rm);
      end else begin
        valid_input = 1'b0;
      end
      @(negedge clk);
    end

    // Reset with two operands in flight.
    valid_input = 1'b1;
    a = 32'h4F7FFFFF;
    rm = 3'd0;
    @(negedge clk);
    a = 32'h3FC00000;
    @(negedge clk);
    valid_input = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_valid", 32'(valid_output), 32'd0);
    check("rst_async_y", y, 32'd0);
    check("rst_async_fflags", 32'(fflags), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("post_rst%0d_valid", i), 32'(valid_output), 32'd0);
      check($sformatf("post_rst%0d_y", i), y, 32'd0);
      check($sformatf("post_rst%0d_fflags", i), 32'(fflags), 32'd0);
    end
    valid_input = 1'b1;
    a  = 32'h40200000;
    rm = 3'd3;
    @(negedge clk);
    valid_input = 1'b0;
    check("first_op_c1_valid", 32'(valid_output), 32'd0);
    @(negedge clk);
    check("first_op_c2_valid", 32'(valid_output), 32'd0);
    check("first_op_c2_y", y, 32'd0);
    @(negedge clk);
    check("first_op_valid", 32'(valid_output), 32'd1);
    check("first_op_y", y, 32'd3);
    check("first_op_fflags", 32'(fflags), 32'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
